// File: rtl/ps2_message_buffer.sv
// PS/2 set-2 scan-code decoder and fixed-length message buffer. Echoes keystrokes to
// the LCD and hands committed messages to the GPIO transmitter over valid/ready.
module ps2_message_buffer #(
    parameter int         MSG_CHARS = 16,
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter int         CNT_W     = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [7:0]             key_code,
    input  logic                   msg_ready,
    output logic                   msg_valid,
    output logic [MSG_CHARS*8-1:0] msg_data,
    output logic                   char_valid,
    output logic [7:0]             char_ascii,
    output logic [CNT_W-1:0]       char_count,
    output logic                   overflow
);

    typedef enum logic {COLLECT, SEND} state_t;
    typedef enum logic [1:0] {K_NONE, K_PRINT, K_BS, K_ENTER} kind_t;

    localparam logic [7:0]       CODE_BREAK = 8'hF0;
    localparam logic [7:0]       CODE_EXT   = 8'hE0;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MSG_CHARS);

    state_t           state_q, state_d;
    logic             break_q, break_d;
    logic             ext_q, ext_d;
    logic             shift_q, shift_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       buf_q [MSG_CHARS];
    logic [7:0]       buf_d [MSG_CHARS];
    logic             char_valid_q, char_valid_d;
    logic [7:0]       char_ascii_q, char_ascii_d;
    logic             overflow_q, overflow_d;

    // Lowercase ASCII for a letter make code, 0 when the code is not a letter.
    function automatic logic [7:0] letter_of(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
            8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
            8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
            8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
            8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
            8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
            8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
            8'h35: return 8'h79;  8'h1A: return 8'h7A;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] digit_of(input logic [7:0] c);
        case (c)
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            default: return 8'h00;
        endcase
    endfunction

    kind_t      kind;
    logic [7:0] key_ascii;
    logic [7:0] letter;
    logic [7:0] digit;
    logic       is_shift;
    logic       handshake;

    always_comb begin
        letter    = letter_of(key_code);
        digit     = digit_of(key_code);
        kind      = K_NONE;
        key_ascii = 8'h00;
        if (letter != 8'h00) begin
            kind      = K_PRINT;
            key_ascii = shift_q ? (letter - 8'd32) : letter;
        end else if (digit != 8'h00) begin
            kind      = K_PRINT;
            key_ascii = digit;
        end else if (key_code == 8'h29) begin
            kind      = K_PRINT;
            key_ascii = 8'h20;
        end else if (key_code == 8'h66) begin
            kind = K_BS;
        end else if (key_code == 8'h5A) begin
            kind = K_ENTER;
        end
    end

    assign is_shift  = (key_code == 8'h12) || (key_code == 8'h59);
    assign handshake = (state_q == SEND) && msg_ready;

    always_comb begin
        // NOTE: every _d starts from its hold value so no path through this block infers a latch.
        state_d      = state_q;
        break_d      = break_q;
        ext_d        = ext_q;
        shift_d      = shift_q;
        count_d      = count_q;
        buf_d        = buf_q;
        char_valid_d = 1'b0;
        char_ascii_d = char_ascii_q;
        overflow_d   = 1'b0;

        if (key_valid) begin
            if (key_code == CODE_BREAK) begin
                break_d = 1'b1;
            end else if (key_code == CODE_EXT) begin
                ext_d = 1'b1;
            end else begin
                break_d = 1'b0;
                ext_d   = 1'b0;
                if (!ext_q) begin
                    if (is_shift) begin
                        shift_d = !break_q;
                    end else if (!break_q && state_q == COLLECT) begin
                        case (kind)
                            K_PRINT: begin
                                if (count_q < CNT_MAX) begin
                                    for (int i = 0; i < MSG_CHARS; i++)
                                        if (count_q == CNT_W'(i)) buf_d[i] = key_ascii;
                                    count_d      = count_q + 1'b1;
                                    char_valid_d = 1'b1;
                                    char_ascii_d = key_ascii;
                                end else begin
                                    overflow_d = 1'b1;
                                end
                            end
                            K_BS: begin
                                if (count_q != '0) begin
                                    for (int i = 0; i < MSG_CHARS; i++)
                                        if (count_q == CNT_W'(i + 1)) buf_d[i] = FILL_CHAR;
                                    count_d      = count_q - 1'b1;
                                    char_valid_d = 1'b1;
                                    char_ascii_d = 8'd127;
                                end
                            end
                            K_ENTER: begin
                                if (count_q != '0) state_d = SEND;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end

        // Completing the handshake wins over any buffer edit on the same cycle.
        if (handshake) begin
            state_d = COLLECT;
            count_d = '0;
            for (int i = 0; i < MSG_CHARS; i++) buf_d[i] = FILL_CHAR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            break_q      <= 1'b0;
            ext_q        <= 1'b0;
            shift_q      <= 1'b0;
            count_q      <= '0;
            char_valid_q <= 1'b0;
            char_ascii_q <= 8'h00;
            overflow_q   <= 1'b0;
            // NOTE: the buffer is reset because msg_data is visible during COLLECT.
            for (int i = 0; i < MSG_CHARS; i++) buf_q[i] <= FILL_CHAR;
        end else begin
            state_q      <= state_d;
            break_q      <= break_d;
            ext_q        <= ext_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            char_valid_q <= char_valid_d;
            char_ascii_q <= char_ascii_d;
            overflow_q   <= overflow_d;
            buf_q        <= buf_d;
        end
    end

    for (genvar g = 0; g < MSG_CHARS; g++) begin : g_slot
        assign msg_data[(MSG_CHARS-g)*8-1 -: 8] = buf_q[g];
    end

    assign msg_valid  = (state_q == SEND);
    assign char_valid = char_valid_q;
    assign char_ascii = char_ascii_q;
    assign char_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_message_buffer.sv
// Directed bench for ps2_message_buffer: a 16-char instance for the main flow and a
// 4-char instance for overflow, sharing the same key/handshake stimulus.
module tb_ps2_message_buffer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid = 1'b0;
    logic [7:0]   key_code = 8'h00;
    logic         msg_ready = 1'b0;

    logic         mv16, cv16, ov16;
    logic [127:0] md16;
    logic [7:0]   ca16;
    logic [4:0]   cc16;

    logic         mv4, cv4, ov4;
    logic [31:0]  md4;
    logic [7:0]   ca4;
    logic [2:0]   cc4;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] ALL_FILL = {16{8'h20}};

    always #5 clock = ~clock;

    ps2_message_buffer dut16 (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .msg_ready(msg_ready), .msg_valid(mv16), .msg_data(md16), .char_valid(cv16),
        .char_ascii(ca16), .char_count(cc16), .overflow(ov16)
    );

    ps2_message_buffer #(.MSG_CHARS(4), .FILL_CHAR(8'h20), .CNT_W(3)) dut4 (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .msg_ready(msg_ready), .msg_valid(mv4), .msg_data(md4), .char_valid(cv4),
        .char_ascii(ca4), .char_count(cc4), .overflow(ov4)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One key_valid pulse; returns at the negedge after the sampling edge.
    task automatic send_key(input logic [7:0] code, input logic ready);
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = code;
        msg_ready = ready;
        @(negedge clock);
        key_valid = 1'b0;
        msg_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] code;
        bit         d4;
        logic       cv;
        logic [7:0] ascii;
        logic [4:0] cnt;
        logic       ov;
        logic       mv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] code, input bit d4, input logic cv,
                       input logic [7:0] ascii, input logic [4:0] cnt,
                       input logic ov, input logic mv);
        vecs.push_back('{code, d4, cv, ascii, cnt, ov, mv});
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_key(vecs[i].code, 1'b0);
            if (vecs[i].d4) begin
                check($sformatf("v%0d cv", i), 128'(cv4), 128'(vecs[i].cv));
                check($sformatf("v%0d cnt", i), 128'(cc4), 128'(vecs[i].cnt));
                check($sformatf("v%0d ov", i), 128'(ov4), 128'(vecs[i].ov));
                if (vecs[i].cv) check($sformatf("v%0d ascii", i), 128'(ca4), 128'(vecs[i].ascii));
            end else begin
                check($sformatf("v%0d cv", i), 128'(cv16), 128'(vecs[i].cv));
                check($sformatf("v%0d cnt", i), 128'(cc16), 128'(vecs[i].cnt));
                check($sformatf("v%0d ov", i), 128'(ov16), 128'(vecs[i].ov));
                check($sformatf("v%0d mv", i), 128'(mv16), 128'(vecs[i].mv));
                if (vecs[i].cv) check($sformatf("v%0d ascii", i), 128'(ca16), 128'(vecs[i].ascii));
            end
        end
    endtask

    int main_last;

    initial begin
        // Shift, backspace, digits, ignored codes, then "hello" + enter.
        add(8'h12, 0, 0, 8'h00, 0, 0, 0);
        add(8'h1C, 0, 1, 8'h41, 1, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 1, 0, 0);
        add(8'h12, 0, 0, 8'h00, 1, 0, 0);
        add(8'h1C, 0, 1, 8'h61, 2, 0, 0);
        add(8'h66, 0, 1, 8'd127, 1, 0, 0);
        add(8'h66, 0, 1, 8'd127, 0, 0, 0);
        add(8'h32, 0, 1, 8'h62, 1, 0, 0);
        add(8'h66, 0, 1, 8'd127, 0, 0, 0);
        add(8'h66, 0, 0, 8'h00, 0, 0, 0);
        add(8'h5A, 0, 0, 8'h00, 0, 0, 0);
        add(8'h45, 0, 1, 8'h30, 1, 0, 0);
        add(8'h12, 0, 0, 8'h00, 1, 0, 0);
        add(8'h16, 0, 1, 8'h31, 2, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 2, 0, 0);
        add(8'h12, 0, 0, 8'h00, 2, 0, 0);
        add(8'h29, 0, 1, 8'h20, 3, 0, 0);
        add(8'h76, 0, 0, 8'h00, 3, 0, 0);
        add(8'hE0, 0, 0, 8'h00, 3, 0, 0);
        add(8'h74, 0, 0, 8'h00, 3, 0, 0);
        add(8'hE0, 0, 0, 8'h00, 3, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 3, 0, 0);
        add(8'h74, 0, 0, 8'h00, 3, 0, 0);
        add(8'hE0, 0, 0, 8'h00, 3, 0, 0);
        add(8'h1C, 0, 0, 8'h00, 3, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 3, 0, 0);
        add(8'h1C, 0, 0, 8'h00, 3, 0, 0);
        add(8'h66, 0, 1, 8'd127, 2, 0, 0);
        add(8'h66, 0, 1, 8'd127, 1, 0, 0);
        add(8'h66, 0, 1, 8'd127, 0, 0, 0);
        add(8'h33, 0, 1, 8'h68, 1, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 1, 0, 0);
        add(8'h33, 0, 0, 8'h00, 1, 0, 0);
        add(8'h24, 0, 1, 8'h65, 2, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 2, 0, 0);
        add(8'h24, 0, 0, 8'h00, 2, 0, 0);
        add(8'h4B, 0, 1, 8'h6C, 3, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 3, 0, 0);
        add(8'h4B, 0, 0, 8'h00, 3, 0, 0);
        add(8'h4B, 0, 1, 8'h6C, 4, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 4, 0, 0);
        add(8'h4B, 0, 0, 8'h00, 4, 0, 0);
        add(8'h44, 0, 1, 8'h6F, 5, 0, 0);
        add(8'hF0, 0, 0, 8'h00, 5, 0, 0);
        add(8'h44, 0, 0, 8'h00, 5, 0, 0);
        add(8'h5A, 0, 0, 8'h00, 5, 0, 1);
        add(8'h1C, 0, 0, 8'h00, 5, 0, 1);
        main_last = vecs.size() - 1;
        // Overflow on the 4-character instance.
        for (int i = 1; i <= 4; i++) add(8'h1C, 1, 1, 8'h61, 5'(i), 0, 0);
        add(8'h1C, 1, 0, 8'h00, 4, 1, 0);
        add(8'h1C, 1, 0, 8'h00, 4, 1, 0);

        // Reset state.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst mv", 128'(mv16), 0);
        check("rst cv", 128'(cv16), 0);
        check("rst ov", 128'(ov16), 0);
        check("rst cnt", 128'(cc16), 0);
        check("rst ascii", 128'(ca16), 0);
        check("rst data", md16, ALL_FILL);

        // Asynchronous reset in the middle of collection after "ab".
        send_key(8'h1C, 1'b0);
        send_key(8'h32, 1'b0);
        check("ab cnt", 128'(cc16), 2);
        check("ab data", md16, {8'h61, 8'h62, {14{8'h20}}});
        #2 reset = 1'b1;
        #1;
        check("arst cnt", 128'(cc16), 0);
        check("arst ascii", 128'(ca16), 0);
        check("arst data", md16, ALL_FILL);
        @(negedge clock);
        reset = 1'b0;
        send_key(8'h1C, 1'b0);
        check("post rst cv", 128'(cv16), 1);
        check("post rst ascii", 128'(ca16), 8'h61);
        check("post rst cnt", 128'(cc16), 1);
        @(negedge clock);
        check("pulse ends", 128'(cv16), 0);
        check("ascii holds", 128'(ca16), 8'h61);
        send_key(8'h66, 1'b0);
        check("cleanup cnt", 128'(cc16), 0);

        run_vecs(0, main_last);
        check("hello data", md16, 128'h68656C6C6F2020202020202020202020);

        // Handshake with a shift make on the same cycle: handshake wins, shift still latches.
        send_key(8'h12, 1'b1);
        check("hs mv", 128'(mv16), 0);
        check("hs cnt", 128'(cc16), 0);
        check("hs cv", 128'(cv16), 0);
        check("hs data", md16, ALL_FILL);
        send_key(8'h1C, 1'b0);
        check("hs shift ascii", 128'(ca16), 8'h41);
        check("hs shift cnt", 128'(cc16), 1);
        send_key(8'hF0, 1'b0);
        send_key(8'h12, 1'b0);
        send_key(8'h5A, 1'b0);
        check("send2 mv", 128'(mv16), 1);
        // Printable on the handshake cycle is dropped.
        send_key(8'h32, 1'b1);
        check("hs2 mv", 128'(mv16), 0);
        check("hs2 cv", 128'(cv16), 0);
        check("hs2 cnt", 128'(cc16), 0);

        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        run_vecs(main_last + 1, vecs.size() - 1);
        check("ovf data", 128'(md4), 128'(32'h61616161));
        @(negedge clock);
        check("ovf pulse ends", 128'(ov4), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
